// File: rtl/dac_iq_pacer.sv
// dac_iq_pacer: FIFO of I/Q sample pairs paced out to a DAC port, I then Q, one sample per tick.
// Optional build macro DAC_PACER_OFFSET_BIN_EN converts two's complement samples to offset binary.

module dac_iq_pacer #(
    parameter int unsigned DAC_WIDTH  = 10,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        SPLB_Clk,
    input  logic                        SPLB_Rst,
    input  logic                        Smp_Wr,
    input  logic [31:0]                 Smp_WrData,
    input  logic                        Enable,
    input  logic [15:0]                 Rate_Div,
    input  logic                        Underrun_Clr,
    output logic                        Smp_Full,
    output logic [$clog2(FIFO_DEPTH):0] Smp_Level,
    output logic [DAC_WIDTH-1:0]        S_Data,
    output logic                        S_IQSel,
    output logic                        S_Wrt,
    output logic                        Underrun
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = 2 * DAC_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OUT_I = 2'd1,
        OUT_Q = 2'd2
    } state_e;

    function automatic logic [DAC_WIDTH-1:0] to_dac(input logic [DAC_WIDTH-1:0] smp);
`ifdef DAC_PACER_OFFSET_BIN_EN
        return smp ^ (DAC_WIDTH'(1) << (DAC_WIDTH - 1));
`else
        return smp;
`endif
    endfunction

    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   full_q, full_d;
    logic [DAC_WIDTH-1:0]   sdata_q, sdata_d;
    logic                   iqsel_q, iqsel_d;
    logic                   wrt_q, wrt_d;
    logic                   under_q, under_d;
    logic [DAC_WIDTH-1:0]   qhold_q, qhold_d;
    logic [PW-1:0]          mem_q [FIFO_DEPTH];

    logic                   run;
    logic                   tick;
    logic                   pop;
    logic                   push;
    logic                   under_set;
    logic                   have_pair;
    logic [PW-1:0]          pair_in;
    logic [PW-1:0]          head;
    logic                   unused_wrdata;

    // Only the low DAC_WIDTH bits of each 16-bit half carry sample data
    assign pair_in       = {Smp_WrData[16 +: DAC_WIDTH], Smp_WrData[0 +: DAC_WIDTH]};
    assign unused_wrdata = ^Smp_WrData;
    assign head          = mem_q[rd_ptr_q];
    assign have_pair     = (level_q != '0);

    // Tick counter runs while enabled or while a pair is still being shown
    always_comb begin
        run   = Enable || (state_q != IDLE);
        tick  = run && (cnt_q >= Rate_Div);
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        under_set = 1'b0;
        sdata_d   = sdata_q;
        iqsel_d   = iqsel_q;
        wrt_d     = 1'b0;
        qhold_d   = qhold_q;

        case (state_q)
            IDLE: begin
                if (tick && Enable && have_pair) begin
                    pop     = 1'b1;
                    state_d = OUT_I;
                    sdata_d = to_dac(head[DAC_WIDTH-1:0]);
                    qhold_d = to_dac(head[PW-1:DAC_WIDTH]);
                    iqsel_d = 1'b1;
                    wrt_d   = 1'b1;
                end
            end
            OUT_I: begin
                if (tick) begin
                    state_d = OUT_Q;
                    sdata_d = qhold_q;
                    iqsel_d = 1'b0;
                    wrt_d   = 1'b1;
                end
            end
            OUT_Q: begin
                if (tick) begin
                    if (Enable && have_pair) begin
                        pop     = 1'b1;
                        state_d = OUT_I;
                        sdata_d = to_dac(head[DAC_WIDTH-1:0]);
                        qhold_d = to_dac(head[PW-1:DAC_WIDTH]);
                        iqsel_d = 1'b1;
                        wrt_d   = 1'b1;
                    end else begin
                        under_set = Enable;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a write while full is only taken when a pop frees the slot
    always_comb begin
        push     = Smp_Wr && (!full_q || pop);
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        full_d   = (level_d == LW'(FIFO_DEPTH));
        under_d  = under_set || (under_q && !Underrun_Clr);
    end

    always_ff @(posedge SPLB_Clk or posedge SPLB_Rst) begin
        if (SPLB_Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            sdata_q  <= '0;
            iqsel_q  <= 1'b0;
            wrt_q    <= 1'b0;
            under_q  <= 1'b0;
            qhold_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            sdata_q  <= sdata_d;
            iqsel_q  <= iqsel_d;
            wrt_q    <= wrt_d;
            under_q  <= under_d;
            qhold_q  <= qhold_d;
        end
    end

    // Sample storage needs no reset: pointers alone define valid contents
    always_ff @(posedge SPLB_Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pair_in;
        end
    end

    assign Smp_Full  = full_q;
    assign Smp_Level = level_q;
    assign S_Data    = sdata_q;
    assign S_IQSel   = iqsel_q;
    assign S_Wrt     = wrt_q;
    assign Underrun  = under_q;

endmodule
